regfile_wb_arbiter: RTL and testbench

// - Write-side front end of the 32x32 register file: merges results from the single-cycle ALU and the

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back front end: request record, grant encoding
// and the x0 filter used before raising the regfile write enable.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_ALU  = 2'd1,
        G_MEM  = 2'd2
    } grant_e;

    localparam wb_req_t REQ_ZERO = '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};

    // x0 is hard-wired to zero, so a result aimed at it is consumed but never written.
    function automatic logic rd_writable(input logic [REG_AW-1:0] rd_i);
        return (rd_i != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding memory/MDU write-back requests until the arbiter grants them.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          mem_q   [DEPTH];
    wb_req_t          mem_d   [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign empty     = (count_q == {(AW + 1){1'b0}});
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_ZERO;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and buffered memory/MDU results onto the regfile's single registered write port.
// Optional macro WB_STATS_EN adds wb_count / stall_count performance counters.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int MEM_DEPTH  = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              we,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data,
`ifdef WB_STATS_EN
    output logic [31:0]       wb_count,
    output logic [31:0]       stall_count,
`endif
    output logic              fifo_full
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    grant_e            grant_s;
    wb_req_t           sel_req_s;
    wb_req_t           fifo_head_s;
    wb_req_t           mem_req_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              we_q, we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

    assign mem_req_s   = '{rd: mem_rd, data: mem_data};
    assign fifo_push_s = mem_valid && !fifo_full_s;
    assign fifo_pop_s  = (grant_s == G_MEM);
    assign mem_ready   = !fifo_full_s;
    assign fifo_full   = fifo_full_s;
    assign alu_ready   = rst_n && (grant_s != G_MEM);
    assign we          = we_q;
    assign rd          = rd_q;
    assign rd_data     = rd_data_q;

    wb_fifo #(
        .DEPTH (MEM_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push_s),
        .push_req (mem_req_s),
        .pop      (fifo_pop_s),
        .head     (fifo_head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // ALU wins unless memory is waiting and the ALU is idle, has starved it, or the FIFO is full.
    always_comb begin
        grant_s = G_NONE;
        if (!fifo_empty_s && (!alu_valid || (starve_cnt_q == STARVE_LIM) || fifo_full_s)) begin
            grant_s = G_MEM;
        end else if (alu_valid) begin
            grant_s = G_ALU;
        end else begin
            grant_s = G_NONE;
        end
    end

    // Select the granted request, build the next write and advance the starvation counter.
    always_comb begin
        sel_req_s    = REQ_ZERO;
        we_d         = 1'b0;
        rd_d         = rd_q;
        rd_data_d    = rd_data_q;
        starve_cnt_d = starve_cnt_q;
        case (grant_s)
            G_ALU:   sel_req_s = '{rd: alu_rd, data: alu_data};
            G_MEM:   sel_req_s = fifo_head_s;
            default: sel_req_s = REQ_ZERO;
        endcase
        if ((grant_s != G_NONE) && rd_writable(sel_req_s.rd)) begin
            we_d      = 1'b1;
            rd_d      = sel_req_s.rd;
            rd_data_d = sel_req_s.data;
        end else begin
            we_d = 1'b0;
        end
        if (fifo_empty_s || (grant_s == G_MEM)) begin
            starve_cnt_d = {SW{1'b0}};
        end else if ((grant_s == G_ALU) && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Registered write port and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            rd_q         <= {REG_AW{1'b0}};
            rd_data_q    <= {XLEN{1'b0}};
            starve_cnt_q <= {SW{1'b0}};
        end else begin
            we_q         <= we_d;
            rd_q         <= rd_d;
            rd_data_q    <= rd_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] wb_count_q, wb_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    assign wb_count    = wb_count_q;
    assign stall_count = stall_count_q;

    // Counters wrap naturally at 2^32.
    always_comb begin
        wb_count_d    = wb_count_q;
        stall_count_d = stall_count_q;
        if (we_q) begin
            wb_count_d = wb_count_q + 32'd1;
        end else begin
            wb_count_d = wb_count_q;
        end
        if (alu_valid && !alu_ready) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q    <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            wb_count_q    <= wb_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expected values are hand-computed.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        fifo_full;
`ifdef WB_STATS_EN
    logic [31:0] wb_count, stall_count;
`endif

    int tests   = 0;
    int fails   = 0;
    int x0_hits = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .we          (we),
        .rd          (rd),
        .rd_data     (rd_data),
`ifdef WB_STATS_EN
        .wb_count    (wb_count),
        .stall_count (stall_count),
`endif
        .fifo_full   (fifo_full)
    );

    always #5 clk = ~clk;

    // Any write enable aimed at x0 is an error.
    always @(posedge clk) begin
        if (we && (rd == 5'd0)) x0_hits <= x0_hits + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        cyc(); cyc();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        rst_n = 1'b1;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready", 32'(alu_ready), 32'd1);
        cyc(); alu_valid = 1'b0;
        chk("alu_we", 32'(we), 32'd1);
        chk("alu_rd", 32'(rd), 32'd5);
        chk("alu_data", rd_data, 32'hDEADBEEF);
        cyc();
        chk("idle_we", 32'(we), 32'd0);
        chk("idle_rd_hold", 32'(rd), 32'd5);

        // Both valid: ALU first, memory forced after three starving ALU grants
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
        #1 chk("both_alu_ready", 32'(alu_ready), 32'd1);
        chk("both_mem_ready", 32'(mem_ready), 32'd1);
        cyc(); mem_valid = 1'b0;
        chk("both_first_rd", 32'(rd), 32'd3);
        for (int i = 0; i < 3; i++) begin
            #1 chk("starve_alu_ready", 32'(alu_ready), 32'd1);
            cyc();
            chk("starve_alu_rd", 32'(rd), 32'd3);
        end
        #1 chk("starve_forced", 32'(alu_ready), 32'd0);
        cyc();
        chk("starve_mem_we", 32'(we), 32'd1);
        chk("starve_mem_rd", 32'(rd), 32'd7);
        chk("starve_mem_data", rd_data, 32'h11);
        cyc(); alu_valid = 1'b0;
        chk("after_mem_alu_rd", 32'(rd), 32'd3);
        cyc();

        // Fill FIFO while ALU streams
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h80;
        cyc(); mem_rd = 5'd9; mem_data = 32'h90;
        chk("fill_alu1", 32'(rd), 32'd4);
        cyc(); mem_valid = 1'b0;
        chk("fill_alu2", 32'(rd), 32'd4);
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_mem_ready", 32'(mem_ready), 32'd0);
        chk("fill_alu_ready", 32'(alu_ready), 32'd0);
        cyc();
        chk("fill_mem1_rd", 32'(rd), 32'd8);
        chk("fill_mem1_data", rd_data, 32'h80);
        cyc(); alu_valid = 1'b0;
        chk("fill_alu3", 32'(rd), 32'd4);
        cyc();
        chk("fill_mem2_rd", 32'(rd), 32'd9);
        chk("fill_mem2_data", rd_data, 32'h90);
        cyc();
        chk("drain_we", 32'(we), 32'd0);
        chk("drain_full", 32'(fifo_full), 32'd0);

        // x0 destination
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        #1 chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        cyc(); alu_valid = 1'b0;
        chk("x0_we", 32'(we), 32'd0);
        cyc();

        // Reset with full FIFO and a pending write
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD;
        cyc(); mem_rd = 5'd14; mem_data = 32'hE;
        cyc();
        chk("pre_rst_full", 32'(fifo_full), 32'd1);
        chk("pre_rst_we", 32'(we), 32'd1);
        rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        #1 chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        chk("mid_rst_full", 32'(fifo_full), 32'd0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        cyc(); rst_n = 1'b1;
        cyc();
        chk("post_rst_we1", 32'(we), 32'd0);
        cyc();
        chk("post_rst_we2", 32'(we), 32'd0);
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);

`ifdef WB_STATS_EN
        chk("stats_wb0", wb_count, 32'd0);
        chk("stats_stall0", stall_count, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'hB0;
        for (int i = 0; i < 9; i++) cyc();
        alu_valid = 1'b0; mem_valid = 1'b0;
        cyc(); cyc();
        chk("stats_wb", wb_count, 32'd10);
        chk("stats_stall", stall_count, 32'd4);
`endif

        chk("x0_never_written", 32'(x0_hits), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
